// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, opcode constants and FSM state type for the ALU sequence driver
package alu_seq_pkg;
  localparam int OPND_W = 8;
  localparam int OP_W = 3;
  localparam int RES_W = 32;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR = 3'd3;
  localparam logic [OP_W-1:0] OP_NOT = 3'd4;
  localparam logic [OP_W-1:0] OP_ZERO = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_e;
endpackage

// File: rtl/alu_seq_driver_if.sv
// alu_seq_driver_if: valid/ready tuple stream carrying (operand, opcode, result)
interface alu_seq_driver_if;
  import alu_seq_pkg::*;
  logic out_valid;
  logic out_ready;
  logic [OPND_W-1:0] out_num1;
  logic [OP_W-1:0] out_op;
  logic [RES_W-1:0] out_result;
  modport master(output out_valid, out_num1, out_op, out_result, input out_ready);
  modport slave(input out_valid, out_num1, out_op, out_result, output out_ready);
endinterface

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected ALU result for a given operand and opcode
module alu_ref_model
  import alu_seq_pkg::*;
(
  input  logic [OPND_W-1:0] num1_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [RES_W-1:0]  exp_o
);
  logic [RES_W-1:0] n;
  assign n = RES_W'(num1_i);
  always_comb
    exp_o = op_i == OP_ADD ? n + 32'd1 :
            op_i == OP_SUB ? 32'd1 - n :
            op_i == OP_AND ? (n & 32'd1) :
            op_i == OP_OR  ? (n | 32'd1) :
            op_i == OP_NOT ? 32'hFFFF_FFFE : '0;
endmodule

// File: rtl/alu_seq_driver.sv
// alu_seq_driver: sweeps operand range x opcodes into the ALU and streams result tuples out
// Define ALU_SEQ_CHECK_EN to enable the internal reference model and err_cnt.
module alu_seq_driver
  import alu_seq_pkg::*;
#(
  parameter int OP_LAST = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPND_W-1:0] num_lo,
  input  logic [OPND_W-1:0] num_hi,
  output logic              busy,
  output logic              done,
  output logic [OPND_W-1:0] alu_num1,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_result,
  alu_seq_driver_if.master  out_if,
  output logic [RES_W-1:0]  checksum,
  output logic [15:0]       err_cnt
);
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(OP_LAST);
  state_e state_q, state_d;
  logic [OPND_W-1:0] num1_q, num1_d, hi_q, hi_d, onum_q, onum_d;
  logic [OP_W-1:0] op_q, op_d, oop_q, oop_d;
  logic [RES_W-1:0] ores_q, ores_d, csum_q, csum_d;
  logic range_ok, more_ops, more_nums;
  assign range_ok = num_lo <= num_hi;
  assign more_ops = op_q < OP_MAX;
  assign more_nums = num1_q < hi_q;
  always_comb begin
    state_d = state_q;
    num1_d = num1_q;
    hi_d = hi_q;
    op_d = op_q;
    onum_d = onum_q;
    oop_d = oop_q;
    ores_d = ores_q;
    csum_d = csum_q;
    case (state_q)
      S_IDLE: if (start) begin
        csum_d = '0;
        hi_d = num_hi;
        state_d = range_ok ? S_DRIVE : S_DONE;
        num1_d = range_ok ? num_lo : num1_q;
        op_d = range_ok ? '0 : op_q;
      end
      S_DRIVE: begin
        onum_d = num1_q;
        oop_d = op_q;
        ores_d = alu_result;
        state_d = S_EMIT;
      end
      // compare before increment so an operand of 255 never wraps
      S_EMIT: if (out_if.out_ready) begin
        csum_d = csum_q + ores_q;
        state_d = more_ops || more_nums ? S_DRIVE : S_DONE;
        op_d = more_ops ? op_q + 1'b1 : more_nums ? '0 : op_q;
        num1_d = !more_ops && more_nums ? num1_q + 1'b1 : num1_q;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      num1_q <= '0;
      hi_q <= '0;
      op_q <= '0;
      onum_q <= '0;
      oop_q <= '0;
      ores_q <= '0;
      csum_q <= '0;
    end else begin
      state_q <= state_d;
      num1_q <= num1_d;
      hi_q <= hi_d;
      op_q <= op_d;
      onum_q <= onum_d;
      oop_q <= oop_d;
      ores_q <= ores_d;
      csum_q <= csum_d;
    end
  end
  assign busy = state_q == S_DRIVE || state_q == S_EMIT;
  assign done = state_q == S_DONE;
  assign alu_num1 = num1_q;
  assign alu_op = op_q;
  assign checksum = csum_q;
  assign out_if.out_valid = state_q == S_EMIT;
  assign out_if.out_num1 = onum_q;
  assign out_if.out_op = oop_q;
  assign out_if.out_result = ores_q;
`ifdef ALU_SEQ_CHECK_EN
  logic [RES_W-1:0] exp_res;
  logic [15:0] err_q, err_d;
  alu_ref_model u_ref (.num1_i(num1_q), .op_i(op_q), .exp_o(exp_res));
  always_comb
    err_d = state_q == S_IDLE && start ? '0 :
            state_q == S_DRIVE && alu_result != exp_res && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
  always_ff @(posedge clk) err_q <= !reset ? '0 : err_d;
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_seq_driver.sv
// tb_alu_seq_driver: randomized self-checking bench against a tuple-list model of the sweep
module tb_alu_seq_driver;
  logic clk = 0;
  logic reset = 0;
  logic start = 0;
  logic [7:0] num_lo = 0, num_hi = 0;
  logic busy, done;
  logic [7:0] alu_num1;
  logic [2:0] alu_op;
  logic [31:0] alu_result, checksum;
  logic [15:0] err_cnt;
  logic fault = 0;
  int vectors = 0, miscompares = 0;
  typedef struct {int n; int op; logic [31:0] r;} tup_t;
  alu_seq_driver_if bus ();
  alu_seq_driver dut (
    .clk(clk), .reset(reset), .start(start), .num_lo(num_lo), .num_hi(num_hi),
    .busy(busy), .done(done), .alu_num1(alu_num1), .alu_op(alu_op),
    .alu_result(alu_result), .out_if(bus), .checksum(checksum), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] golden(input int n, input int op);
    case (op)
      0: return 32'(n + 1);
      1: return 32'(1 - n);
      2: return 32'(n & 1);
      3: return 32'(n | 1);
      4: return 32'hFFFF_FFFE;
      default: return 32'd0;
    endcase
  endfunction
  assign alu_result = fault && alu_op == 3'd0 ? 32'd0 : golden(int'(alu_num1), int'(alu_op));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_alu_num1"}, alu_num1, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_out_num1"}, bus.out_num1, 0);
    chk({tag, "_out_op"}, bus.out_op, 0);
    chk({tag, "_out_result"}, bus.out_result, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask
  task automatic run_sweep(input int lo, input int hi, input bit rand_ready, input bit mid_start, input int done_lat);
    tup_t q[$];
    tup_t t;
    logic [31:0] csum = 0;
    int nerr = 0, ntup, cyc, n_hs = 0, last_n = -1, last_op = -1, budget;
    bit got_done, hs, prev_valid = 0, prev_hs = 0;
    logic [7:0] p_num;
    logic [2:0] p_op;
    logic [31:0] p_res;
    for (int n = lo; n <= hi; n++)
      for (int op = 0; op <= 5; op++) begin
        t.n = n;
        t.op = op;
        t.r = fault && op == 0 ? 32'd0 : golden(n, op);
        if (fault && op == 0) nerr++;
        csum += t.r;
        q.push_back(t);
      end
`ifndef ALU_SEQ_CHECK_EN
    nerr = 0;
`endif
    ntup = q.size();
    budget = 8 * ntup + 20;
    @(negedge clk);
    start = 1;
    num_lo = 8'(lo);
    num_hi = 8'(hi);
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    chk("busy_after_start", busy, 32'(lo <= hi));
    chk("done_after_start", done, 32'(lo > hi));
    got_done = done;
    while (!got_done && cyc < budget) begin
      if (bus.out_valid) chk("no_b2b_valid", prev_hs, 0);
      if (bus.out_valid && prev_valid && !prev_hs) begin
        chk("stall_num1", bus.out_num1, p_num);
        chk("stall_op", bus.out_op, p_op);
        chk("stall_result", bus.out_result, p_res);
      end
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        n_hs++;
        if (q.size() == 0) chk("extra_tuple", n_hs, ntup);
        else begin
          t = q.pop_front();
          chk("tuple_num1", bus.out_num1, t.n);
          chk("tuple_op", bus.out_op, t.op);
          chk("tuple_result", bus.out_result, t.r);
          last_n = int'(bus.out_num1);
          last_op = int'(bus.out_op);
        end
      end
      if (mid_start && cyc == 40) begin
        start = 1;
        num_lo = 8'd7;
        num_hi = 8'd200;
      end else start = 0;
      prev_valid = bus.out_valid;
      prev_hs = hs;
      p_num = bus.out_num1;
      p_op = bus.out_op;
      p_res = bus.out_result;
      @(negedge clk);
      cyc++;
      got_done = done;
    end
    start = 0;
    chk("done_seen", got_done, 1);
    if (done_lat > 0) chk("done_latency", cyc, done_lat);
    chk("tuples_left", q.size(), 0);
    chk("tuple_count", n_hs, ntup);
    if (lo <= hi) begin
      chk("last_num1", last_n, hi);
      chk("last_op", last_op, 5);
    end
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", bus.out_valid, 0);
    chk("checksum", checksum, csum);
    chk("err_cnt", err_cnt, nerr);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("checksum_hold", checksum, csum);
  endtask
  initial begin
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1;
    run_sweep(3, 3, 0, 0, 13);
    run_sweep(0, 1, 1, 0, 0);
    run_sweep(10, 9, 0, 0, 1);
    run_sweep(0, 255, 0, 1, 3073);
    @(negedge clk);
    start = 1;
    num_lo = 0;
    num_hi = 3;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    bus.out_ready = 0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    chk("valid_before_reset", bus.out_valid, 1);
    reset = 0;
    @(negedge clk);
    check_reset("reset_mid");
    reset = 1;
    bus.out_ready = 1;
    run_sweep(250, 255, 1, 0, 0);
    fault = 1;
    run_sweep(5, 6, 0, 0, 25);
    fault = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
